// File: rtl/tl_pkg.sv
// Shared types and constants for the two-road intersection sequencer.
package tl_pkg;

  // Controller states; code 3'd7 is unused and recovers to AR_EW.
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_NS = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_EW = 3'd5,
    WALK  = 3'd6
  } state_t;

  // Light head encoding {R,Y,G}.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  // Road selectors.
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Green state belonging to a road.
  function automatic state_t green_of(input logic dir);
    return (dir == DIR_EW) ? EW_G : NS_G;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase counter: clears on request, otherwise counts up, optionally
// saturating at a limit; flags when the count equals a compare value.
module tl_phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] sat_limit,
  input  logic [CNT_W-1:0] cmp_val,
  output logic [CNT_W-1:0] count,
  output logic             at_cmp
);

  // Count register: clear wins, then saturation hold, then increment.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sat_en && (count >= sat_limit)) begin
      count <= count;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_cmp = (count == cmp_val);

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer with demand-actuated greens, all-red
// clearance, an exclusive pedestrian WALK phase and emergency pre-emption.
module intersection_controller
  import tl_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int T_GREEN_MIN = 6,
  parameter int T_GREEN_MAX = 12,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       emerg,
  input  logic       emerg_dir,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  // Last counter value of each timed phase.
  localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST  = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(T_WALK - 1);

  state_t           state, next_state;
  logic             next_dir, next_dir_d;
  logic [CNT_W-1:0] count, cmp_val;
  logic             at_cmp, in_green, phase_change;

  assign phase_change = (next_state != state);

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (phase_change),
    .sat_en    (in_green),
    .sat_limit (GMAX_LAST),
    .cmp_val   (cmp_val),
    .count     (count),
    .at_cmp    (at_cmp)
  );

  // Next-state selection and the per-state compare value for the timer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    next_state = state;
    next_dir_d = next_dir;
    cmp_val    = '0;
    in_green   = 1'b0;
    case (state)
      NS_G: begin
        in_green = 1'b1;
        cmp_val  = GMAX_LAST;
        if (emerg) begin
          if (emerg_dir == DIR_EW) next_state = NS_Y;
        end else if ((count >= GMIN_LAST) && (ew_car || ped_pending) &&
                     (!ns_car || at_cmp)) begin
          next_state = NS_Y;
        end
      end
      EW_G: begin
        in_green = 1'b1;
        cmp_val  = GMAX_LAST;
        if (emerg) begin
          if (emerg_dir == DIR_NS) next_state = EW_Y;
        end else if ((count >= GMIN_LAST) && (ns_car || ped_pending) &&
                     (!ew_car || at_cmp)) begin
          next_state = EW_Y;
        end
      end
      NS_Y: begin
        cmp_val = YEL_LAST;
        if (at_cmp) next_state = AR_NS;
      end
      EW_Y: begin
        cmp_val = YEL_LAST;
        if (at_cmp) next_state = AR_EW;
      end
      AR_NS: begin
        cmp_val = AR_LAST;
        if (at_cmp) begin
          if (ped_pending && !emerg) begin
            next_state = WALK;
            next_dir_d = DIR_EW;
          end else if (emerg) begin
            next_state = green_of(emerg_dir);
          end else begin
            next_state = EW_G;
          end
        end
      end
      AR_EW: begin
        cmp_val = AR_LAST;
        if (at_cmp) begin
          if (ped_pending && !emerg) begin
            next_state = WALK;
            next_dir_d = DIR_NS;
          end else if (emerg) begin
            next_state = green_of(emerg_dir);
          end else begin
            next_state = NS_G;
          end
        end
      end
      WALK: begin
        cmp_val = WALK_LAST;
        // Pre-emption aborts the walk at once; it is not retried.
        if (emerg) begin
          next_state = green_of(emerg_dir);
        end else if (at_cmp) begin
          next_state = green_of(next_dir);
        end
      end
      default: next_state = AR_EW;
    endcase
  end

  // State and post-walk direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= AR_EW;
      next_dir <= DIR_NS;
    end else begin
      state    <= next_state;
      next_dir <= next_dir_d;
    end
  end

  // Pedestrian latch: cleared as WALK is entered, set by a press outside WALK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending <= 1'b0;
    end else if ((next_state == WALK) && (state != WALK)) begin
      ped_pending <= 1'b0;
    end else if (ped_req && (state != WALK)) begin
      ped_pending <= 1'b1;
    end
  end

  // Light and walk decode straight from the state register.
  always_comb begin
    ns_lights = LIGHT_RED;
    ew_lights = LIGHT_RED;
    walk      = 1'b0;
    case (state)
      NS_G:    ns_lights = LIGHT_GRN;
      NS_Y:    ns_lights = LIGHT_YEL;
      EW_G:    ew_lights = LIGHT_GRN;
      EW_Y:    ew_lights = LIGHT_YEL;
      WALK:    walk      = 1'b1;
      default: walk      = 1'b0;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: directed scenarios plus a
// randomized run, all compared against a phase-level reference model.
module tb_intersection_controller;

  localparam int CNT_W       = 24;
  localparam int T_GREEN_MIN = 6;
  localparam int T_GREEN_MAX = 12;
  localparam int T_YELLOW    = 3;
  localparam int T_ALLRED    = 2;
  localparam int T_WALK      = 4;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Model phase kinds.
  localparam int K_GRN = 0;
  localparam int K_YEL = 1;
  localparam int K_CLR = 2;
  localparam int K_WLK = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       ns_car, ew_car, ped_req, emerg, emerg_dir;
  logic [2:0] ns_lights, ew_lights, state_o;
  logic       walk, ped_pending;

  int checks = 0;
  int errors = 0;

  // Reference model: phase kind, owning road, cycles elapsed in phase.
  int m_kind;
  int m_e;
  bit m_road;
  bit m_ped;
  bit m_nd;

  intersection_controller #(
    .CNT_W       (CNT_W),
    .T_GREEN_MIN (T_GREEN_MIN),
    .T_GREEN_MAX (T_GREEN_MAX),
    .T_YELLOW    (T_YELLOW),
    .T_ALLRED    (T_ALLRED),
    .T_WALK      (T_WALK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ns_car      (ns_car),
    .ew_car      (ew_car),
    .ped_req     (ped_req),
    .emerg       (emerg),
    .emerg_dir   (emerg_dir),
    .ns_lights   (ns_lights),
    .ew_lights   (ew_lights),
    .walk        (walk),
    .ped_pending (ped_pending),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_kind = K_CLR;
    m_road = 1'b1;
    m_e    = 0;
    m_ped  = 1'b0;
    m_nd   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int nk;
    bit nr;
    bit own;
    bit other;
    if (reset) begin
      model_reset();
      return;
    end
    nk = m_kind;
    nr = m_road;
    own   = m_road ? ew_car : ns_car;
    other = m_road ? ns_car : ew_car;
    case (m_kind)
      K_GRN: begin
        if (emerg) begin
          if (emerg_dir != m_road) nk = K_YEL;
        end else if (m_e >= T_GREEN_MIN - 1 && (other || m_ped) &&
                     (!own || m_e >= T_GREEN_MAX - 1)) begin
          nk = K_YEL;
        end
      end
      K_YEL: if (m_e == T_YELLOW - 1) nk = K_CLR;
      K_CLR: begin
        if (m_e == T_ALLRED - 1) begin
          if (m_ped && !emerg) begin
            nk   = K_WLK;
            m_nd = !m_road;
          end else begin
            nk = K_GRN;
            nr = emerg ? emerg_dir : !m_road;
          end
        end
      end
      default: begin
        if (emerg) begin
          nk = K_GRN;
          nr = emerg_dir;
        end else if (m_e == T_WALK - 1) begin
          nk = K_GRN;
          nr = m_nd;
        end
      end
    endcase
    if (nk == K_WLK && m_kind != K_WLK) m_ped = 1'b0;
    else if (ped_req && m_kind != K_WLK) m_ped = 1'b1;
    if (nk != m_kind || nr != m_road) m_e = 0;
    else m_e++;
    m_kind = nk;
    m_road = nr;
  endtask

  function automatic logic [2:0] exp_head(input bit road);
    if (m_road == road && m_kind == K_GRN) return GRN;
    if (m_road == road && m_kind == K_YEL) return YEL;
    return RED;
  endfunction

  task automatic check_all();
    chk("ns_lights", ns_lights, exp_head(1'b0));
    chk("ew_lights", ew_lights, exp_head(1'b1));
    chk("walk", {2'b00, walk}, {2'b00, (m_kind == K_WLK)});
    chk("ped_pending", {2'b00, ped_pending}, {2'b00, m_ped});
    chk("both_roads_open", {2'b00, (ns_lights !== RED && ew_lights !== RED)}, 3'b000);
    chk("walk_not_all_red", {2'b00, (walk && (ns_lights !== RED || ew_lights !== RED))}, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  function automatic logic [2:0] sel_val(input int sel);
    case (sel)
      0:       return ns_lights;
      1:       return ew_lights;
      default: return {2'b00, walk};
    endcase
  endfunction

  // Number of further cycles the selected output keeps value v.
  task automatic measure(input int sel, input logic [2:0] v, output int n);
    n = 0;
    while (sel_val(sel) === v && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_for(input string tag, input int sel, input logic [2:0] v);
    int k;
    k = 0;
    while (sel_val(sel) !== v && k < 200) begin
      tick();
      k++;
    end
    chk(tag, sel_val(sel), v);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0; emerg = 1'b0; emerg_dir = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ns", ns_lights, RED);
    chk("reset_ew", ew_lights, RED);
    chk("reset_walk", {2'b00, walk}, 3'b000);
    chk("reset_ped", {2'b00, ped_pending}, 3'b000);

    // Release: two all-red cycles, then NS green.
    reset = 1'b0;
    tick();
    chk("rel_c1_ns", ns_lights, RED);
    tick();
    chk("rel_c2_ns", ns_lights, GRN);
    chk("rel_c2_ew", ew_lights, RED);

    // No demand: NS green rests.
    repeat (29) tick();
    chk("rest_ns", ns_lights, GRN);
    ew_car = 1'b1;
    tick();
    chk("demand_yel", ns_lights, YEL);
    measure(0, YEL, n);  chk_int("ns_yel_len", n, T_YELLOW);
    measure(1, RED, n);  chk_int("ar_ns_len", n, T_ALLRED);
    chk("ew_green", ew_lights, GRN);

    // EW green with only cross demand: minimum green.
    ns_car = 1'b1; ew_car = 1'b0;
    measure(1, GRN, n);  chk_int("ew_min_green", n, T_GREEN_MIN);
    ew_car = 1'b1;
    measure(1, YEL, n);  chk_int("ew_yel_len", n, T_YELLOW);
    measure(0, RED, n);  chk_int("ar_ew_len", n, T_ALLRED);
    // Both roads busy: maximum green.
    measure(0, GRN, n);  chk_int("ns_max_green", n, T_GREEN_MAX);

    // Pedestrian request served by an exclusive walk.
    ns_car = 1'b0; ew_car = 1'b0;
    wait_for("reach_ew_g", 1, GRN);
    ns_car = 1'b1;
    wait_for("reach_ns_g", 0, GRN);
    ns_car = 1'b0;
    tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("ped_latched", {2'b00, ped_pending}, 3'b001);
    measure(0, GRN, n);  chk_int("ped_green_len", n + 2, T_GREEN_MIN);
    measure(0, YEL, n);  chk_int("ped_yel_len", n, T_YELLOW);
    measure(2, 3'b000, n); chk_int("ped_ar_len", n, T_ALLRED);
    chk("walk_on", {2'b00, walk}, 3'b001);
    chk("ped_cleared", {2'b00, ped_pending}, 3'b000);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("ped_dropped_in_walk", {2'b00, ped_pending}, 3'b000);
    measure(2, 3'b001, n); chk_int("walk_len", n + 1, T_WALK);
    chk("after_walk_ew", ew_lights, GRN);

    // Emergency pre-emption toward EW.
    ns_car = 1'b1;
    wait_for("reach_ns_g2", 0, GRN);
    tick();
    tick();
    emerg = 1'b1; emerg_dir = 1'b1; ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("emerg_yel", ns_lights, YEL);
    measure(0, YEL, n);  chk_int("emerg_yel_len", n, T_YELLOW);
    measure(1, RED, n);  chk_int("emerg_ar_len", n, T_ALLRED);
    chk("emerg_ew_green", ew_lights, GRN);
    repeat (50) tick();
    chk("emerg_hold", ew_lights, GRN);
    chk("emerg_ped_kept", {2'b00, ped_pending}, 3'b001);
    emerg = 1'b0;
    tick();
    chk("emerg_drop_yel", ew_lights, YEL);
    measure(1, YEL, n);  chk_int("post_emerg_yel", n, T_YELLOW);
    measure(2, 3'b000, n); chk_int("post_emerg_ar", n, T_ALLRED);
    chk("post_emerg_walk", {2'b00, walk}, 3'b001);

    // Reset during NS yellow with a pending request.
    wait_for("reach_ns_g3", 0, GRN);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    wait_for("reach_ns_y", 0, YEL);
    chk("ped_before_reset", {2'b00, ped_pending}, 3'b001);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midreset_ns", ns_lights, RED);
    chk("midreset_ew", ew_lights, RED);
    chk("midreset_ped", {2'b00, ped_pending}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rerel_c1_ns", ns_lights, RED);
    tick();
    chk("rerel_c2_ns", ns_lights, GRN);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) ns_car = ~ns_car;
      if ($urandom_range(7) == 0) ew_car = ~ew_car;
      ped_req = ($urandom_range(15) == 0);
      if ($urandom_range(39) == 0) begin
        emerg = ~emerg;
        if (emerg) emerg_dir = $urandom_range(1);
      end
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
